// File: rtl/vec_mem_sequencer.sv
// rtl/vec_mem_sequencer.sv - multi-beat vector load/store sequencer in front of a single-ported data memory
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   start, memread, memwrite request pulse from decode and its load/store qualifiers
//   base_addr, wdata_vec    word address of element 0 and the store vector
//   busy, done, err         pipeline stall, completion pulse, illegal-request pulse
//   rdata_vec               assembled load result (element i at [i*EW +: EW])
//   mem_addr, mem_re, mem_we, mem_wdata, mem_ready, mem_rdata   memory port
module vec_mem_sequencer #(
    parameter int ELEMS = 4,
    parameter int EW    = 16,
    parameter int AW    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [AW-1:0]         base_addr,
    input  logic [ELEMS*EW-1:0]   wdata_vec,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ELEMS*EW-1:0]   rdata_vec,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [EW-1:0]         mem_wdata,
    input  logic                  mem_ready,
    input  logic [EW-1:0]         mem_rdata
);

    localparam int BW = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_DRAIN = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [BW-1:0]         beat;
    logic [AW-1:0]         base_q;
    logic [ELEMS*EW-1:0]   wvec_q;
    logic [ELEMS*EW-1:0]   rvec_q;
    logic [BW-1:0]         pend_idx;
    logic                  pend_valid;
    logic                  err_q;
    logic                  last_beat;
    logic                  load_req;
    logic                  store_req;

    assign last_beat = (beat == BW'(ELEMS - 1));
    assign load_req  = start & memread & ~memwrite;
    assign store_req = start & memwrite & ~memread;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (load_req) begin
                    state_next = S_RD;
                end else if (store_req) begin
                    state_next = S_WR;
                end
            end
            S_RD:    if (mem_ready && last_beat) state_next = S_DRAIN;
            S_DRAIN: state_next = S_DONE;
            S_WR:    if (mem_ready && last_beat) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: beat counter, latched request, read capture
    always_ff @(posedge clk) begin
        if (reset) begin
            beat       <= '0;
            base_q     <= '0;
            wvec_q     <= '0;
            rvec_q     <= '0;
            pend_idx   <= '0;
            pend_valid <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) & start & memread & memwrite;

            // Read data arrives one cycle after acceptance; the pending
            // register remembers which element it belongs to.
            pend_valid <= (state == S_RD) & mem_ready;
            if (state == S_RD && mem_ready) begin
                pend_idx <= beat;
            end
            if (pend_valid) begin
                rvec_q[int'(pend_idx)*EW +: EW] <= mem_rdata;
            end

            case (state)
                S_IDLE: begin
                    if (load_req || store_req) begin
                        base_q <= base_addr;
                        beat   <= '0;
                    end
                    if (store_req) begin
                        wvec_q <= wdata_vec;
                    end
                end
                S_RD, S_WR: begin
                    if (mem_ready && !last_beat) begin
                        beat <= beat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy      = (state == S_RD) || (state == S_DRAIN) || (state == S_WR);
        done      = (state == S_DONE);
        err       = err_q;
        rdata_vec = rvec_q;
        mem_re    = (state == S_RD);
        mem_we    = (state == S_WR);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == S_RD || state == S_WR) begin
            mem_addr = base_q + AW'(beat);
        end
        if (state == S_WR) begin
            mem_wdata = wvec_q[int'(beat)*EW +: EW];
        end
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb/tb_vec_mem_sequencer.sv - self-checking bench for vec_mem_sequencer
module tb_vec_mem_sequencer;

    localparam int ELEMS = 4;
    localparam int EW    = 16;
    localparam int AW    = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                memread = 1'b0;
    logic                memwrite = 1'b0;
    logic [AW-1:0]       base_addr = '0;
    logic [ELEMS*EW-1:0] wdata_vec = '0;
    logic                busy;
    logic                done;
    logic                err;
    logic [ELEMS*EW-1:0] rdata_vec;
    logic [AW-1:0]       mem_addr;
    logic                mem_re;
    logic                mem_we;
    logic [EW-1:0]       mem_wdata;
    logic                mem_ready = 1'b0;
    logic [EW-1:0]       mem_rdata = '0;

    logic [EW-1:0]       mem [0:65535];
    int                  checks = 0;
    int                  failures = 0;
    logic [ELEMS*EW-1:0] last_rdata = '0;
    bit                  ready_q[$];

    bit                  acc_rd = 1'b0;
    bit                  acc_wr = 1'b0;
    logic [AW-1:0]       acc_addr = '0;
    logic [EW-1:0]       acc_data = '0;

    vec_mem_sequencer #(.ELEMS(ELEMS), .EW(EW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .memread(memread), .memwrite(memwrite),
        .base_addr(base_addr), .wdata_vec(wdata_vec), .busy(busy), .done(done), .err(err),
        .rdata_vec(rdata_vec), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: record accepted requests mid-cycle, respond just after the edge
    always @(negedge clk) begin
        acc_rd   = mem_re & mem_ready;
        acc_wr   = mem_we & mem_ready;
        acc_addr = mem_addr;
        acc_data = mem_wdata;
    end

    always @(posedge clk) begin
        #1;
        if (acc_rd) mem_rdata = mem[acc_addr];
        if (acc_wr) mem[acc_addr] = acc_data;
        acc_rd = 1'b0;
        acc_wr = 1'b0;
    end

    function automatic bit next_ready(input int pct);
        if (ready_q.size() > 0) return ready_q.pop_front();
        return int'($urandom_range(99)) >= pct;
    endfunction

    // Presents start for one cycle; returns 1 time unit into cycle T+1
    task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] base,
                         input logic [ELEMS*EW-1:0] wv);
        @(posedge clk); #1;
        start = 1'b1; memread = rd; memwrite = wr; base_addr = base; wdata_vec = wv;
        @(posedge clk); #1;
        start = 1'b0; memread = 1'b0; memwrite = 1'b0;
        base_addr = AW'($urandom);
        wdata_vec = {$urandom, $urandom};
    endtask

    task automatic run_load(input logic [AW-1:0] base, input int pct);
        logic [ELEMS*EW-1:0] exp;
        logic [AW-1:0]       ea;
        int                  i;
        int                  n;
        for (int k = 0; k < ELEMS; k++) begin
            ea = base + AW'(k);
            exp[k*EW +: EW] = mem[ea];
        end
        issue(1'b1, 1'b0, base, '0);
        mem_ready = next_ready(pct);
        i = 0;
        n = 0;
        while (i < ELEMS && n < 200) begin
            @(negedge clk);
            ea = base + AW'(i);
            checks++;
            if ({busy, mem_re, mem_we, done, err} !== 5'b11000 || mem_addr !== ea) begin
                failures++;
                $display("FAIL load_req beat=%0d: flags=%b addr=%h, expected flags=11000 addr=%h",
                         i, {busy, mem_re, mem_we, done, err}, mem_addr, ea);
            end
            if (mem_ready) i++;
            @(posedge clk); #1;
            mem_ready = next_ready(pct);
            n++;
        end
        checks++;
        if (i != ELEMS) begin
            failures++;
            $display("FAIL load_timeout: beats=%0d, expected %0d", i, ELEMS);
        end
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_we, done, err} !== 5'b10000) begin
            failures++;
            $display("FAIL load_drain: flags=%b, expected 10000", {busy, mem_re, mem_we, done, err});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_we, done, err} !== 5'b00010 || rdata_vec !== exp) begin
            failures++;
            $display("FAIL load_done: flags=%b rdata=%h, expected flags=00010 rdata=%h",
                     {busy, mem_re, mem_we, done, err}, rdata_vec, exp);
        end
        last_rdata = exp;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_we, done, err} !== 5'b00000 || rdata_vec !== exp) begin
            failures++;
            $display("FAIL load_idle: flags=%b rdata=%h, expected flags=00000 rdata=%h",
                     {busy, mem_re, mem_we, done, err}, rdata_vec, exp);
        end
    endtask

    task automatic run_store(input logic [AW-1:0] base, input int pct,
                             input logic [ELEMS*EW-1:0] wv);
        logic [AW-1:0] ea;
        logic [EW-1:0] ed;
        int            i;
        int            n;
        issue(1'b0, 1'b1, base, wv);
        mem_ready = next_ready(pct);
        i = 0;
        n = 0;
        while (i < ELEMS && n < 200) begin
            @(negedge clk);
            ea = base + AW'(i);
            ed = wv[i*EW +: EW];
            checks++;
            if ({busy, mem_re, mem_we, done, err} !== 5'b10100 || mem_addr !== ea || mem_wdata !== ed) begin
                failures++;
                $display("FAIL store_req beat=%0d: flags=%b addr=%h data=%h, expected flags=10100 addr=%h data=%h",
                         i, {busy, mem_re, mem_we, done, err}, mem_addr, mem_wdata, ea, ed);
            end
            if (mem_ready) i++;
            @(posedge clk); #1;
            mem_ready = next_ready(pct);
            n++;
        end
        checks++;
        if (i != ELEMS) begin
            failures++;
            $display("FAIL store_timeout: beats=%0d, expected %0d", i, ELEMS);
        end
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_we, done, err} !== 5'b00010 || rdata_vec !== last_rdata) begin
            failures++;
            $display("FAIL store_done: flags=%b rdata=%h, expected flags=00010 rdata=%h",
                     {busy, mem_re, mem_we, done, err}, rdata_vec, last_rdata);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_we, done, err} !== 5'b00000) begin
            failures++;
            $display("FAIL store_idle: flags=%b, expected 00000", {busy, mem_re, mem_we, done, err});
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_we, done, err} !== 5'b00000 || mem_addr !== '0 ||
            mem_wdata !== '0 || rdata_vec !== '0) begin
            failures++;
            $display("FAIL reset_values: flags=%b addr=%h wdata=%h rdata=%h, expected all zero",
                     {busy, mem_re, mem_we, done, err}, mem_addr, mem_wdata, rdata_vec);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        last_rdata = '0;
    endtask

    task automatic test_load;
        logic [ELEMS*EW-1:0] want;
        want = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        for (int k = 0; k < ELEMS; k++) mem[16'h0010 + k] = 16'h00A0 + EW'(k);
        run_load(16'h0010, 0);
        checks++;
        if (rdata_vec !== want) begin
            failures++;
            $display("FAIL load_plan_data: rdata=%h, expected %h", rdata_vec, want);
        end
    endtask

    task automatic test_store;
        logic [ELEMS*EW-1:0] wv;
        logic [EW-1:0]       got;
        wv = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        run_store(16'h0100, 0, wv);
        for (int k = 0; k < ELEMS; k++) begin
            got = mem[16'h0100 + k];
            checks++;
            if (got !== wv[k*EW +: EW]) begin
                failures++;
                $display("FAIL store_mem[%0d]: got %h, expected %h", k, got, wv[k*EW +: EW]);
            end
        end
    endtask

    task automatic test_stall;
        ready_q = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < ELEMS; k++) mem[16'h0010 + k] = EW'($urandom);
        run_load(16'h0010, 0);
    endtask

    task automatic test_wrap;
        for (int k = 0; k < ELEMS; k++) mem[AW'(16'hFFFE + k)] = EW'($urandom);
        run_load(16'hFFFE, 0);
    endtask

    task automatic test_err;
        issue(1'b1, 1'b1, 16'h0040, '0);
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_we, done, err} !== 5'b00001) begin
            failures++;
            $display("FAIL err_pulse: flags=%b, expected 00001", {busy, mem_re, mem_we, done, err});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({busy, mem_re, mem_we, done, err} !== 5'b00000) begin
            failures++;
            $display("FAIL err_clear: flags=%b, expected 00000", {busy, mem_re, mem_we, done, err});
        end
        issue(1'b0, 1'b0, 16'h0050, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, mem_re, mem_we, done, err} !== 5'b00000 || rdata_vec !== last_rdata) begin
                failures++;
                $display("FAIL nop_ignored cyc=%0d: flags=%b rdata=%h, expected flags=00000 rdata=%h",
                         c, {busy, mem_re, mem_we, done, err}, rdata_vec, last_rdata);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid;
        // Store aborted during beat 2
        mem_ready = 1'b1;
        issue(1'b0, 1'b1, 16'h0200, {$urandom, $urandom});
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0202) begin
            failures++;
            $display("FAIL abort_beat2: we=%b addr=%h, expected we=1 addr=0202", mem_we, mem_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        last_rdata = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, mem_re, mem_we, done, err} !== 5'b00000 || mem_addr !== '0 || mem_wdata !== '0) begin
                failures++;
                $display("FAIL abort_store cyc=%0d: flags=%b addr=%h wdata=%h, expected all zero",
                         c, {busy, mem_re, mem_we, done, err}, mem_addr, mem_wdata);
            end
            @(posedge clk); #1;
        end
        // Load aborted with a read outstanding: its late data must be dropped
        for (int k = 0; k < ELEMS; k++) mem[16'h0300 + k] = 16'h8000 | EW'(k + 1);
        issue(1'b1, 1'b0, 16'h0300, '0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, mem_re, mem_we, done, err} !== 5'b00000 || rdata_vec !== '0) begin
                failures++;
                $display("FAIL abort_load cyc=%0d: flags=%b rdata=%h, expected flags=00000 rdata=0",
                         c, {busy, mem_re, mem_we, done, err}, rdata_vec);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < ELEMS; k++) mem[16'h0020 + k] = EW'($urandom);
        run_load(16'h0020, 0);
    endtask

    task automatic test_random;
        logic [AW-1:0] base;
        for (int t = 0; t < 12; t++) begin
            base = AW'($urandom);
            if ($urandom_range(1) == 0) begin
                run_load(base, 35);
            end else begin
                run_store(base, 35, {$urandom, $urandom});
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = EW'($urandom);
        test_reset();
        test_load();
        test_store();
        test_stall();
        test_wrap();
        test_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1);
    end

endmodule
